// File: rtl/membus_arbiter_pkg.sv
// membus_arbiter_pkg
//   Shared memory-bus definitions: address/data widths, the byte-mask width
//   derived from the data width, and the arbiter state encoding that later
//   multi-port interconnect blocks reuse.
//   No ports (package).
package membus_arbiter_pkg;

    localparam int XLEN              = 64;
    localparam int MEMBUS_DATA_WIDTH = 64;
    localparam int MEMBUS_MASK_WIDTH = MEMBUS_DATA_WIDTH / 8;

    typedef logic [XLEN-1:0] Addr;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state;

endpackage

// File: rtl/membus_arbiter_if.sv
// Membus
//   Single-outstanding memory bus bundle.
//   Request:  valid, ready, addr, wen, wdata, wmask  (master -> slave, ready back)
//   Response: rvalid, rdata                          (slave -> master)
//   Modports: master (issues requests), slave (serves requests).
interface Membus;
    import membus_arbiter_pkg::*;

    logic                         valid;
    logic                         ready;
    Addr                          addr;
    logic                         wen;
    logic [MEMBUS_DATA_WIDTH-1:0] wdata;
    logic [MEMBUS_MASK_WIDTH-1:0] wmask;
    logic                         rvalid;
    logic [MEMBUS_DATA_WIDTH-1:0] rdata;

    modport master (
        output valid, addr, wen, wdata, wmask,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wdata, wmask,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/membus_arbiter.sv
// membus_arbiter
//   Shares one downstream Membus between the fetch port (0) and the
//   load/store port (1). One transaction outstanding at a time; the read
//   response is routed back to the port that issued the request.
//   Ports:
//     clk       system clock, rising edge
//     rst       synchronous, active-low reset
//     i_membus  fetch requester (slave side)
//     d_membus  load/store requester (slave side)
//     membus    downstream port toward the device decoder (master side)
//   Parameter ROUND_ROBIN: 1 alternates grants on conflict, 0 gives port 1
//   fixed priority.
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    Membus.slave  i_membus,
    Membus.slave  d_membus,
    Membus.master membus
);

    arb_state state_q, state_d;
    logic     owner_q, owner_d;
    logic     last_q,  last_d;
    logic     sel;
    logic     fwd_valid;

    // Conflict resolution: round-robin picks the port that did not win last
    // time; with nobody requesting the result is unused.
    function automatic logic grant_select(input logic i_valid,
                                          input logic d_valid,
                                          input logic last);
        if (i_valid && d_valid) begin
            return ROUND_ROBIN ? !last : 1'b1;
        end
        return d_valid;
    endfunction

    // Forwarding, upstream handshake and response routing are all
    // combinational so the arbiter adds no latency in either direction.
    // While reset is held every handshake output is forced low.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        sel       = grant_select(i_membus.valid, d_membus.valid, last_q);
        fwd_valid = 1'b0;

        membus.valid    = 1'b0;
        membus.addr     = sel ? d_membus.addr  : i_membus.addr;
        membus.wen      = sel ? d_membus.wen   : i_membus.wen;
        membus.wdata    = sel ? d_membus.wdata : i_membus.wdata;
        membus.wmask    = sel ? d_membus.wmask : i_membus.wmask;

        i_membus.ready  = 1'b0;
        d_membus.ready  = 1'b0;
        i_membus.rvalid = 1'b0;
        d_membus.rvalid = 1'b0;
        i_membus.rdata  = membus.rdata;
        d_membus.rdata  = membus.rdata;

        if (rst) begin
            case (state_q)
                ARB_IDLE: begin
                    fwd_valid      = sel ? d_membus.valid : i_membus.valid;
                    membus.valid   = fwd_valid;
                    i_membus.ready = !sel && membus.ready;
                    d_membus.ready =  sel && membus.ready;
                    if (fwd_valid && membus.ready) begin
                        owner_d = sel;
                        last_d  = sel;
                        state_d = ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    // No new grant in the response cycle; a stray rvalid in
                    // IDLE never reaches this branch and is dropped.
                    if (membus.rvalid) begin
                        i_membus.rvalid = !owner_q;
                        d_membus.rvalid =  owner_q;
                        state_d         = ARB_IDLE;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    // last resets to 1 so that port 0 wins the first round-robin conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter
//   Two arbiter instances side by side: instance 0 with ROUND_ROBIN=1,
//   instance 1 with ROUND_ROBIN=0. A transaction-level model tracks whether
//   each instance has a transaction outstanding, who owns it and who won
//   last; a compare process checks every output against it each cycle.
//   Directed scenarios pin the model with literal expectations, then a
//   randomized phase exercises stalls, latencies, stray responses and resets.
module tb_membus_arbiter;
    import membus_arbiter_pkg::*;

    typedef struct {
        logic                         valid;
        Addr                          addr;
        logic                         wen;
        logic [MEMBUS_DATA_WIDTH-1:0] wdata;
        logic [MEMBUS_MASK_WIDTH-1:0] wmask;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    req_t                         up        [2][2];
    logic                         ds_ready  [2];
    logic                         ds_rvalid [2];
    logic [MEMBUS_DATA_WIDTH-1:0] ds_rdata  [2];

    wire                          up_ready  [2][2];
    wire                          up_rvalid [2][2];
    wire  [MEMBUS_DATA_WIDTH-1:0] up_rdata  [2][2];
    wire                          m_valid   [2];
    wire                          m_wen     [2];
    wire  [XLEN-1:0]              m_addr    [2];
    wire  [MEMBUS_DATA_WIDTH-1:0] m_wdata   [2];
    wire  [MEMBUS_MASK_WIDTH-1:0] m_wmask   [2];

    // Transaction-level model state
    bit  m_busy  [2];
    bit  m_owner [2];
    bit  m_last  [2];
    bit  acc     [2][2];
    int  acc_cyc [2];
    int  acc_lat [2];
    int  cyc;

    // Stimulus knobs
    int                           lat      [2];
    bit                           stray    [2];
    logic [MEMBUS_DATA_WIDTH-1:0] rsp_data [2];
    bit                           auto_mode;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        Membus ibus();
        Membus dbus();
        Membus mbus();

        assign ibus.valid = up[k][0].valid;
        assign ibus.addr  = up[k][0].addr;
        assign ibus.wen   = up[k][0].wen;
        assign ibus.wdata = up[k][0].wdata;
        assign ibus.wmask = up[k][0].wmask;
        assign dbus.valid = up[k][1].valid;
        assign dbus.addr  = up[k][1].addr;
        assign dbus.wen   = up[k][1].wen;
        assign dbus.wdata = up[k][1].wdata;
        assign dbus.wmask = up[k][1].wmask;

        assign up_ready[k][0]  = ibus.ready;
        assign up_ready[k][1]  = dbus.ready;
        assign up_rvalid[k][0] = ibus.rvalid;
        assign up_rvalid[k][1] = dbus.rvalid;
        assign up_rdata[k][0]  = ibus.rdata;
        assign up_rdata[k][1]  = dbus.rdata;

        assign mbus.ready  = ds_ready[k];
        assign mbus.rvalid = ds_rvalid[k];
        assign mbus.rdata  = ds_rdata[k];
        assign m_valid[k]  = mbus.valid;
        assign m_addr[k]   = mbus.addr;
        assign m_wen[k]    = mbus.wen;
        assign m_wdata[k]  = mbus.wdata;
        assign m_wmask[k]  = mbus.wmask;

        membus_arbiter #(.ROUND_ROBIN(k == 0)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .i_membus (ibus),
            .d_membus (dbus),
            .membus   (mbus)
        );
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    // Which port the arbitration rules pick for instance k right now.
    function automatic logic model_sel(input int k);
        if (up[k][0].valid && up[k][1].valid) return (k == 0) ? !m_last[k] : 1'b1;
        return up[k][1].valid;
    endfunction

    task automatic applyStimulus(input int k, input int p, input logic v, input Addr a,
                                 input logic w, input logic [63:0] d, input logic [7:0] m);
        up[k][p].valid = v;
        up[k][p].addr  = a;
        up[k][p].wen   = w;
        up[k][p].wdata = d;
        up[k][p].wmask = m;
    endtask

    task automatic clearReq();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) up[k][p].valid = 1'b0;
    endtask

    // Downstream responder and requester bookkeeping, run just after each edge.
    task automatic driverStep();
        for (int k = 0; k < 2; k++) begin
            ds_rvalid[k] = 1'b0;
            if (m_busy[k] && cyc == acc_cyc[k] + acc_lat[k] - 1) begin
                ds_rvalid[k] = 1'b1;
                ds_rdata[k]  = auto_mode ? {$urandom, $urandom} : rsp_data[k];
            end else if (!m_busy[k] && stray[k]) begin
                ds_rvalid[k] = 1'b1;
                ds_rdata[k]  = {$urandom, $urandom};
            end
            stray[k] = 1'b0;
            for (int p = 0; p < 2; p++) if (acc[k][p]) up[k][p].valid = 1'b0;
            if (auto_mode) begin
                ds_ready[k] = 1'($urandom);
                lat[k]      = 1 + int'($urandom_range(3, 0));
                for (int p = 0; p < 2; p++) begin
                    if (!up[k][p].valid && $urandom_range(2, 0) == 0)
                        applyStimulus(k, p, 1'b1, {$urandom, $urandom}, 1'($urandom),
                                      {$urandom, $urandom}, 8'($urandom));
                end
                stray[k] = !m_busy[k] && ($urandom_range(7, 0) == 0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        driverStep();
        #1;
    endtask

    // Model update on each rising edge, from the arbitration rules.
    initial begin
        logic s;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_owner[k] = 0; m_last[k] = 1;
            acc[k][0] = 0; acc[k][1] = 0; acc_cyc[k] = 0; acc_lat[k] = 1;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                acc[k][0] = 0;
                acc[k][1] = 0;
                if (!rst) begin
                    m_busy[k] = 0; m_owner[k] = 0; m_last[k] = 1;
                end else if (!m_busy[k]) begin
                    s = model_sel(k);
                    if (up[k][s].valid && ds_ready[k]) begin
                        m_busy[k]  = 1;
                        m_owner[k] = s;
                        m_last[k]  = s;
                        acc[k][s]  = 1;
                        acc_cyc[k] = cyc;
                        acc_lat[k] = lat[k];
                    end
                end else if (ds_rvalid[k]) begin
                    m_busy[k] = 0;
                end
            end
        end
    end

    // Compare process: every output of both instances, every cycle.
    initial forever begin
        logic s;
        logic ev;
        logic pl;
        logic er;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                checkBit($sformatf("k%0d_rst_mvalid", k), m_valid[k], 1'b0);
                for (int p = 0; p < 2; p++) begin
                    checkBit($sformatf("k%0d_rst_ready%0d", k, p), up_ready[k][p], 1'b0);
                    checkBit($sformatf("k%0d_rst_rvalid%0d", k, p), up_rvalid[k][p], 1'b0);
                end
            end else if (!m_busy[k]) begin
                s  = model_sel(k);
                ev = up[k][0].valid | up[k][1].valid;
                checkBit($sformatf("k%0d_mvalid", k), m_valid[k], ev);
                if (ev) begin
                    checkOutput($sformatf("k%0d_addr", k), m_addr[k], up[k][s].addr);
                    checkBit($sformatf("k%0d_wen", k), m_wen[k], up[k][s].wen);
                    checkOutput($sformatf("k%0d_wdata", k), m_wdata[k], up[k][s].wdata);
                    checkOutput($sformatf("k%0d_wmask", k), 64'(m_wmask[k]), 64'(up[k][s].wmask));
                end
                for (int p = 0; p < 2; p++) begin
                    pl = 1'(p);
                    if (up[k][p].valid)
                        checkBit($sformatf("k%0d_ready%0d", k, p), up_ready[k][p],
                                 (pl == s) ? ds_ready[k] : 1'b0);
                    checkBit($sformatf("k%0d_idle_rvalid%0d", k, p), up_rvalid[k][p], 1'b0);
                end
            end else begin
                checkBit($sformatf("k%0d_wait_mvalid", k), m_valid[k], 1'b0);
                for (int p = 0; p < 2; p++) begin
                    pl = 1'(p);
                    er = (pl == m_owner[k]) && ds_rvalid[k];
                    checkBit($sformatf("k%0d_wait_ready%0d", k, p), up_ready[k][p], 1'b0);
                    checkBit($sformatf("k%0d_rvalid%0d", k, p), up_rvalid[k][p], er);
                    if (er) checkOutput($sformatf("k%0d_rdata%0d", k, p), up_rdata[k][p], ds_rdata[k]);
                end
            end
        end
    end

    Addr exp_rr [3] = '{64'h1000, 64'h2000, 64'h1000};
    Addr exp_fp [3] = '{64'h2000, 64'h2000, 64'h2000};
    int  win_rr [3] = '{0, 1, 0};
    int  win_fp [3] = '{1, 1, 1};

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        int w;
        auto_mode = 0;
        for (int k = 0; k < 2; k++) begin
            ds_ready[k] = 1; ds_rvalid[k] = 0; ds_rdata[k] = '0;
            lat[k] = 1; stray[k] = 0; rsp_data[k] = '0;
            for (int p = 0; p < 2; p++) applyStimulus(k, p, 1'b1, 64'h10, 1'b0, 64'h0, 8'h0);
        end
        rst = 1'b0;

        // Reset holds every handshake low even with both ports requesting.
        @(negedge clk);
        checkBit("lit_rst_mvalid", m_valid[0], 1'b0);
        checkBit("lit_rst_ready0", up_ready[0][0], 1'b0);
        checkBit("lit_rst_ready1", up_ready[0][1], 1'b0);
        tick();
        clearReq();
        rst = 1'b1;

        // Single fetch, 1-cycle device.
        for (int k = 0; k < 2; k++) begin
            rsp_data[k] = 64'h1234;
            applyStimulus(k, 0, 1'b1, 64'h8000_0000, 1'b0, 64'h0, 8'h0);
        end
        @(negedge clk);
        checkBit("lit_fetch_mvalid", m_valid[0], 1'b1);
        checkOutput("lit_fetch_addr", m_addr[0], 64'h8000_0000);
        checkBit("lit_fetch_ready", up_ready[0][0], 1'b1);
        tick();
        @(negedge clk);
        checkBit("lit_fetch_rvalid_i", up_rvalid[0][0], 1'b1);
        checkOutput("lit_fetch_rdata_i", up_rdata[0][0], 64'h1234);
        checkBit("lit_fetch_rvalid_d", up_rvalid[0][1], 1'b0);
        tick();

        // Simultaneous requests from reset.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 2; k++) begin
                applyStimulus(k, 0, 1'b1, 64'h1000, 1'b0, 64'h0, 8'h0);
                applyStimulus(k, 1, 1'b1, 64'h2000, 1'b0, 64'h0, 8'h0);
            end
            @(negedge clk);
            checkOutput($sformatf("lit_rr_addr_t%0d", t), m_addr[0], exp_rr[t]);
            checkOutput($sformatf("lit_fp_addr_t%0d", t), m_addr[1], exp_fp[t]);
            checkBit($sformatf("lit_rr_loser_ready_t%0d", t), up_ready[0][1 - win_rr[t]], 1'b0);
            checkBit($sformatf("lit_fp_loser_ready_t%0d", t), up_ready[1][1 - win_fp[t]], 1'b0);
            tick();
            @(negedge clk);
            checkBit($sformatf("lit_rr_rvalid_t%0d", t), up_rvalid[0][win_rr[t]], 1'b1);
            checkBit($sformatf("lit_fp_rvalid_t%0d", t), up_rvalid[1][win_fp[t]], 1'b1);
            checkOutput($sformatf("lit_rr_loser_addr_t%0d", t), up[0][1 - win_rr[t]].addr,
                        (win_rr[t] == 0) ? 64'h2000 : 64'h1000);
            tick();
        end

        // Fixed priority: port 0 goes once port 1 stops asking.
        for (int k = 0; k < 2; k++) begin
            up[k][1].valid = 1'b0;
            applyStimulus(k, 0, 1'b1, 64'h1000, 1'b0, 64'h0, 8'h0);
        end
        @(negedge clk);
        checkOutput("lit_fp_port0_addr", m_addr[1], 64'h1000);
        checkBit("lit_fp_port0_ready", up_ready[1][0], 1'b1);
        tick();
        @(negedge clk);
        checkBit("lit_fp_port0_rvalid", up_rvalid[1][0], 1'b1);
        tick();

        // MSIP write from the data port.
        clearReq();
        for (int k = 0; k < 2; k++) applyStimulus(k, 1, 1'b1, 64'h0200_0000, 1'b1, 64'h1, 8'hFF);
        @(negedge clk);
        checkBit("lit_msip_mvalid", m_valid[0], 1'b1);
        checkOutput("lit_msip_addr", m_addr[0], 64'h0200_0000);
        checkBit("lit_msip_wen", m_wen[0], 1'b1);
        checkOutput("lit_msip_wdata", m_wdata[0], 64'h1);
        checkOutput("lit_msip_wmask", 64'(m_wmask[0]), 64'hFF);
        tick();
        @(negedge clk);
        checkBit("lit_msip_rvalid_d", up_rvalid[0][1], 1'b1);
        checkBit("lit_msip_rvalid_i", up_rvalid[0][0], 1'b0);
        tick();
        @(negedge clk);
        checkBit("lit_msip_rvalid_once", up_rvalid[0][1], 1'b0);
        tick();

        // Downstream stall for 3 cycles, then a 4-cycle response.
        for (int k = 0; k < 2; k++) begin
            ds_ready[k] = 1'b0;
            applyStimulus(k, 0, 1'b1, 64'h3000, 1'b0, 64'h0, 8'h0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkBit($sformatf("lit_stall_mvalid_c%0d", c), m_valid[0], 1'b1);
            checkBit($sformatf("lit_stall_ready_c%0d", c), up_ready[0][0], 1'b0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            ds_ready[k] = 1'b1;
            lat[k] = 4;
        end
        @(negedge clk);
        checkBit("lit_stall_accept", up_ready[0][0], 1'b1);
        tick();
        for (int k = 0; k < 2; k++) applyStimulus(k, 1, 1'b1, 64'h4000, 1'b0, 64'h0, 8'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkBit($sformatf("lit_slow_ready0_c%0d", c), up_ready[0][0], 1'b0);
            checkBit($sformatf("lit_slow_ready1_c%0d", c), up_ready[0][1], 1'b0);
            checkBit($sformatf("lit_slow_rvalid_c%0d", c), up_rvalid[0][0], 1'b0);
            tick();
        end
        @(negedge clk);
        checkBit("lit_slow_rvalid", up_rvalid[0][0], 1'b1);
        for (int k = 0; k < 2; k++) lat[k] = 1;
        tick();
        @(negedge clk);
        checkOutput("lit_after_slow_addr", m_addr[0], 64'h4000);
        tick();
        tick();
        clearReq();
        tick();

        // Reset during WAIT, stray response in the first IDLE cycle.
        for (int k = 0; k < 2; k++) begin
            lat[k] = 4;
            applyStimulus(k, 0, 1'b1, 64'h5000, 1'b0, 64'h0, 8'h0);
        end
        @(negedge clk);
        checkBit("lit_rstwait_accept", up_ready[0][0], 1'b1);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) stray[k] = 1'b1;
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkBit("lit_stray_rvalid_i", up_rvalid[0][0], 1'b0);
        checkBit("lit_stray_rvalid_d", up_rvalid[0][1], 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            lat[k] = 1;
            applyStimulus(k, 0, 1'b1, 64'h5000, 1'b0, 64'h0, 8'h0);
            applyStimulus(k, 1, 1'b1, 64'h6000, 1'b0, 64'h0, 8'h0);
        end
        @(negedge clk);
        checkOutput("lit_post_rst_rr_addr", m_addr[0], 64'h5000);
        checkOutput("lit_post_rst_fp_addr", m_addr[1], 64'h6000);
        tick();
        clearReq();
        tick();
        tick();

        // Randomized traffic with occasional resets.
        $display("[TB] random phase");
        auto_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(199, 0) != 0);
        end
        auto_mode = 0;
        rst = 1'b1;
        clearReq();
        for (int k = 0; k < 2; k++) ds_ready[k] = 1'b1;
        w = 0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
